// File: rtl/johnson_pkg.sv
// Shared state encoding, default width and Johnson-code legality check
// for the Johnson sequencer controller.
package johnson_pkg;

   localparam int N_DEF      = 4;
   localparam int LEGAL_MAXW = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DONE  = 3'd3,
      ST_FAULT = 3'd4
   } state_e;

   // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
   function automatic logic johnson_legal(input logic [LEGAL_MAXW-1:0] q, input int n);
      int edges;
      edges = 0;
      for (int i = 0; i < LEGAL_MAXW-1; i++) begin
         if ((i < n-1) && (q[i] != q[i+1])) edges = edges + 1;
      end
      return (edges <= 1);
   endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson shift register with synchronous clear, seed load, direction
// select and hold. Updates on the falling edge of CLK.
module johnson_core import johnson_pkg::*; #(
   parameter int N = N_DEF
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [N-1:0] load_val_i,
   input  logic         adv_i,
   input  logic         dir_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (load_i) begin
         q_d = load_val_i;
      end else if (adv_i) begin
         if (dir_i) q_d = {~q_q[0], q_q[N-1:1]};
         else       q_d = {q_q[N-2:0], ~q_q[N-1]};
      end
   end

   always_ff @(negedge CLK or negedge CLR) begin
      if (!CLR) q_q <= '0;
      else      q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run/step sequencer around a Johnson register: revolution counting,
// stop handling and illegal-code fault recovery.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting; seed load honoured, start begins a run
// ST_RUN   | advance every clock until terminal count or stop
// ST_STEP  | advance only on clocks with step=1
// ST_DONE  | one-cycle completion pulse, Q holds
// ST_FAULT | Q was illegal: Q cleared, err set, back to idle
module johnson_seq_ctrl import johnson_pkg::*; #(
   parameter int N = N_DEF
) (
   input  logic                   CLK,
   input  logic                   CLR,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   dir,
   input  logic                   step_mode,
   input  logic                   step,
   input  logic [3:0]             revs,
   input  logic                   load_en,
   input  logic [N-1:0]           load_val,
   output logic [N-1:0]           Q,
   output logic [$clog2(2*N)-1:0] phase,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int PH_W  = $clog2(2*N);
   localparam int CNT_W = PH_W + 4;
   localparam logic [CNT_W-1:0] REV_LEN = CNT_W'(2*N);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       revs_q, revs_d;
   logic             err_q, err_d;
   logic             fault_run_q, fault_run_d;
   logic             core_clr, core_load, core_adv;
   logic             q_legal;
   logic             load_legal;
   int               ones;

   johnson_core #(.N(N)) u_core (
      .CLK        (CLK),
      .CLR        (CLR),
      .clr_i      (core_clr),
      .load_i     (core_load),
      .load_val_i (load_val),
      .adv_i      (core_adv),
      .dir_i      (dir),
      .q_o        (Q)
   );

   assign q_legal    = johnson_legal(LEGAL_MAXW'(Q), N);
   assign load_legal = johnson_legal(LEGAL_MAXW'(load_val), N);

   // cnt_q is a down-counter of remaining advances; with revs=0 it simply wraps.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      revs_d      = revs_q;
      err_d       = err_q;
      fault_run_d = fault_run_q;
      core_clr    = 1'b0;
      core_load   = 1'b0;
      core_adv    = 1'b0;
      if (!q_legal) begin
         state_d     = ST_FAULT;
         err_d       = 1'b1;
         core_clr    = 1'b1;
         fault_run_d = (state_q == ST_RUN) || (state_q == ST_STEP);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_en) begin
                  core_load = 1'b1;
                  if (load_legal) err_d = 1'b0;
               end else if (start) begin
                  state_d = step_mode ? ST_STEP : ST_RUN;
                  revs_d  = revs;
                  cnt_d   = CNT_W'(revs) * REV_LEN;
               end
            end
            ST_RUN, ST_STEP: begin
               if (stop) begin
                  state_d = ST_DONE;
               end else if ((state_q == ST_RUN) || step) begin
                  core_adv = 1'b1;
                  cnt_d    = cnt_q - 1'b1;
                  if ((revs_q != 4'd0) && (cnt_q == CNT_W'(1))) state_d = ST_DONE;
               end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(negedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         revs_q      <= '0;
         err_q       <= 1'b0;
         fault_run_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         revs_q      <= revs_d;
         err_q       <= err_d;
         fault_run_q <= fault_run_d;
      end
   end

   // Phase index: ones count on the rising half of the cycle, 2N minus it on the falling half.
   always_comb begin
      ones  = 0;
      for (int i = 0; i < N; i++) ones = ones + int'(Q[i]);
      phase = '0;
      if (q_legal) begin
         if (Q[0] || (Q == '0)) phase = PH_W'(ones);
         else                   phase = PH_W'(2*N - ones);
      end
   end

   assign busy = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign done = (state_q == ST_DONE) || ((state_q == ST_FAULT) && fault_run_q);
   assign err  = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl with a phase-index reference model
// checked against the DUT every cycle.
module tb_johnson_seq_ctrl;

   localparam int N = 4;
   localparam int P = 2*N;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_STEP  = 2;
   localparam int M_DONE  = 3;
   localparam int M_FAULT = 4;

   logic         CLK = 1'b0;
   logic         CLR = 1'b1;
   logic         start = 1'b0, stop = 1'b0, dir = 1'b0, step_mode = 1'b0, step = 1'b0, load_en = 1'b0;
   logic [3:0]   revs = 4'd0;
   logic [N-1:0] load_val = '0;
   logic [N-1:0] Q;
   logic [2:0]   phase;
   logic         busy, done, err;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   logic [N-1:0] m_q;
   int           m_mode;
   int           m_left;
   bit           m_free, m_err, m_frun;

   logic [3:0] fwd [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
   int         pat [10] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0};

   johnson_seq_ctrl #(.N(N)) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .start     (start),
      .stop      (stop),
      .dir       (dir),
      .step_mode (step_mode),
      .step      (step),
      .revs      (revs),
      .load_en   (load_en),
      .load_val  (load_val),
      .Q         (Q),
      .phase     (phase),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 CLK = ~CLK;

   // Johnson code for phase index k: k low ones, or top-aligned ones past N.
   function automatic logic [N-1:0] q_of(input int k);
      if (k <= N) return N'((1 << k) - 1);
      return N'(~((1 << (k - N)) - 1));
   endfunction

   function automatic int phase_of(input logic [N-1:0] q);
      for (int k = 0; k < P; k++) if (q_of(k) == q) return k;
      return -1;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin : model
      int k;
      forever begin
         @(negedge CLK or negedge CLR);
         if (!CLR) begin
            m_q = '0; m_mode = M_IDLE; m_left = 0; m_free = 1'b0; m_err = 1'b0; m_frun = 1'b0;
         end else begin
            k = phase_of(m_q);
            if (k < 0) begin
               m_frun = (m_mode == M_RUN) || (m_mode == M_STEP);
               m_mode = M_FAULT; m_err = 1'b1; m_q = '0;
            end else begin
               case (m_mode)
                  M_IDLE: begin
                     if (load_en) begin
                        m_q = load_val;
                        if (phase_of(load_val) >= 0) m_err = 1'b0;
                     end else if (start) begin
                        m_mode = step_mode ? M_STEP : M_RUN;
                        m_left = int'(revs) * P;
                        m_free = (revs == 4'd0);
                     end
                  end
                  M_RUN, M_STEP: begin
                     if (stop) begin
                        m_mode = M_DONE;
                     end else if ((m_mode == M_RUN) || step) begin
                        k   = dir ? (k + P - 1) % P : (k + 1) % P;
                        m_q = q_of(k);
                        if (!m_free) begin
                           m_left--;
                           if (m_left == 0) m_mode = M_DONE;
                        end
                     end
                  end
                  default: m_mode = M_IDLE;
               endcase
            end
         end
      end
   end

   initial begin : compare
      int k;
      forever begin
         @(posedge CLK);
         if (chk_on) begin
            k = phase_of(m_q);
            cmp("Q", 32'(Q), 32'(m_q));
            cmp("phase", 32'(phase), (k < 0) ? 32'd0 : 32'(k));
            cmp("busy", 32'(busy), 32'((m_mode == M_RUN) || (m_mode == M_STEP)));
            cmp("done", 32'(done), 32'((m_mode == M_DONE) || ((m_mode == M_FAULT) && m_frun)));
            cmp("err", 32'(err), 32'(m_err));
         end
      end
   end

   initial begin : stim
      int busy_cnt, done_cnt;
      #2 CLR = 1'b0;
      chk_on = 1'b1;
      cyc(); cyc();
      cmp("lit_rst_q", 32'(Q), 32'd0);
      cmp("lit_rst_busy", 32'(busy), 32'd0);
      CLR = 1'b1;
      cyc();

      // One forward revolution
      revs = 4'd1; dir = 1'b0; step_mode = 1'b0; start = 1'b1;
      cyc();
      start = 1'b0;
      cmp("lit_rev_q0", 32'(Q), 32'd0);
      busy_cnt = int'(busy); done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         cmp("lit_rev_q", 32'(Q), 32'(fwd[i]));
         if (i == 4) cmp("lit_rev_phase5", 32'(phase), 32'd5);
         busy_cnt += int'(busy);
         done_cnt += int'(done);
      end
      cmp("lit_rev_done8", 32'(done), 32'd1);
      cyc();
      done_cnt += int'(done);
      cmp("lit_rev_busy_cnt", 32'(busy_cnt), 32'd8);
      cmp("lit_rev_done_cnt", 32'(done_cnt), 32'd1);

      // Reverse free-run from a seed, stopped after three clocks
      load_en = 1'b1; load_val = 4'b0011;
      cyc();
      load_en = 1'b0;
      cmp("lit_seed_phase", 32'(phase), 32'd2);
      start = 1'b1; dir = 1'b1; revs = 4'd0;
      cyc();
      start = 1'b0;
      cyc(); cmp("lit_rv_q1", 32'(Q), 32'b0001);
      cyc(); cmp("lit_rv_q2", 32'(Q), 32'b0000);
      cyc(); cmp("lit_rv_q3", 32'(Q), 32'b1000);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cmp("lit_rv_done", 32'(done), 32'd1);
      cmp("lit_rv_hold", 32'(Q), 32'b1000);
      cyc();
      cmp("lit_rv_hold2", 32'(Q), 32'b1000);

      // Step mode: four spread-out steps
      load_en = 1'b1; load_val = 4'b0000; dir = 1'b0;
      cyc();
      load_en = 1'b0; start = 1'b1; step_mode = 1'b1; revs = 4'd1;
      cyc();
      start = 1'b0; step_mode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step = (pat[i] != 0);
         cyc();
      end
      step = 1'b0;
      cmp("lit_step_q", 32'(Q), 32'b1111);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cmp("lit_step_done", 32'(done), 32'd1);
      cmp("lit_step_hold", 32'(Q), 32'b1111);
      cyc();

      // Stop coincides with the final step
      load_en = 1'b1; load_val = 4'b0000;
      cyc();
      load_en = 1'b0; start = 1'b1; step_mode = 1'b1; revs = 4'd1;
      cyc();
      start = 1'b0; step_mode = 1'b0; step = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         cyc();
         done_cnt += int'(done);
      end
      cmp("lit_fin_q7", 32'(Q), 32'b1000);
      stop = 1'b1;
      cyc();
      done_cnt += int'(done);
      step = 1'b0; stop = 1'b0;
      cmp("lit_fin_noadv", 32'(Q), 32'b1000);
      cyc();
      done_cnt += int'(done);
      cmp("lit_fin_done_cnt", 32'(done_cnt), 32'd1);

      // Load and start together: load first, start on the next idle cycle
      load_en = 1'b1; start = 1'b1; load_val = 4'b0001; revs = 4'd0; dir = 1'b0;
      cyc();
      load_en = 1'b0;
      cmp("lit_ls_busy0", 32'(busy), 32'd0);
      cmp("lit_ls_q", 32'(Q), 32'b0001);
      cyc();
      start = 1'b0;
      cmp("lit_ls_busy1", 32'(busy), 32'd1);
      load_en = 1'b1; load_val = 4'b1111;
      cyc();
      load_en = 1'b0;
      cmp("lit_ls_noload", 32'(Q), 32'b0011);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cyc();

      // Illegal seed: fault, even with start held
      load_en = 1'b1; start = 1'b1; load_val = 4'b0101;
      cyc();
      load_en = 1'b0;
      cmp("lit_bad_phase", 32'(phase), 32'd0);
      cyc();
      start = 1'b0;
      cmp("lit_flt_err", 32'(err), 32'd1);
      cmp("lit_flt_q", 32'(Q), 32'd0);
      cmp("lit_flt_busy", 32'(busy), 32'd0);
      cyc();
      cmp("lit_flt_sticky", 32'(err), 32'd1);
      load_en = 1'b1; load_val = 4'b0111;
      cyc();
      load_en = 1'b0;
      cmp("lit_flt_clear", 32'(err), 32'd0);

      // Fault again, then run with err still set and clear mid-run
      load_en = 1'b1; load_val = 4'b1001;
      cyc();
      load_en = 1'b0;
      cyc(); cyc();
      start = 1'b1; revs = 4'd2; dir = 1'b0;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      cmp("lit_clr_pre_q", 32'(Q), 32'b1110);
      cmp("lit_clr_pre_err", 32'(err), 32'd1);
      #2 CLR = 1'b0;
      #1;
      cmp("lit_clr_q", 32'(Q), 32'd0);
      cmp("lit_clr_phase", 32'(phase), 32'd0);
      cmp("lit_clr_busy", 32'(busy), 32'd0);
      cmp("lit_clr_done", 32'(done), 32'd0);
      cmp("lit_clr_err", 32'(err), 32'd0);
      cyc();
      CLR = 1'b1;
      start = 1'b1; revs = 4'd1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 8; i++) cyc();
      cmp("lit_post_done", 32'(done), 32'd1);
      cmp("lit_post_q", 32'(Q), 32'd0);
      cyc(); cyc();

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
